// File: rtl/cpu_defs.sv
// Shared CPU datapath definitions: default word width and destination encodings.
package cpu_defs;

    localparam int unsigned DEFAULT_DATA_WIDTH = 8;
    localparam int unsigned CNT_WIDTH          = 8;

    // Destination select encodings for the write-back demux
    localparam logic DEST_REG = 1'b0;
    localparam logic DEST_MEM = 1'b1;

endpackage

// File: rtl/sync_fifo_8bits.sv
// Small synchronous FIFO with a registered head word; DEPTH must be a power of two >= 2.
module sync_fifo_8bits
    import cpu_defs::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW-1:0]         rd_nxt;
    logic [CW-1:0]         count;
    logic [CW-1:0]         count_nxt;
    logic [DATA_WIDTH-1:0] head_nxt;
    logic                  push_ok;
    logic                  pop_ok;

    // Guard against overflow/underflow even if the caller misbehaves
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    // Next count, read pointer and head word (head holds its value when the FIFO drains)
    always_comb begin
        count_nxt = count;
        rd_nxt    = rd_ptr + AW'(pop_ok);
        head_nxt  = dout;
        case ({push_ok, pop_ok})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
        if ((count - CW'(pop_ok)) != CW'(0)) begin
            head_nxt = mem[rd_nxt];
        end else if (push_ok) begin
            head_nxt = din;
        end
    end

    // Storage array; contents are meaningless until written, so no reset
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers, occupancy, flags and head register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
            dout   <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr <= rd_nxt;
            count  <= count_nxt;
            full   <= (count_nxt == CW'(DEPTH));
            empty  <= (count_nxt == CW'(0));
            dout   <= head_nxt;
        end
    end

endmodule

// File: rtl/demux_1x2_8bits.sv
// Registered 1-to-2 demux: steers each accepted word into one of two per-destination FIFOs.
// Optional delivered-word counters are built when DEMUX_1X2_COUNT_EN is defined.
module demux_1x2_8bits
    import cpu_defs::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned DEPTH      = 2
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_sel,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out0_data,
    output logic                  out0_valid,
    input  logic                  out0_ready,
    output logic [DATA_WIDTH-1:0] out1_data,
    output logic                  out1_valid,
    input  logic                  out1_ready,
    output logic [CNT_WIDTH-1:0]  cnt0,
    output logic [CNT_WIDTH-1:0]  cnt1
);

    logic full0;
    logic full1;
    logic empty0;
    logic empty1;
    logic accept;
    logic push0;
    logic push1;
    logic pop0;
    logic pop1;

    // Ready mux: only the selected FIFO's registered full flag matters
    assign in_ready = ~RESET & ~((in_sel == DEST_MEM) ? full1 : full0);
    assign accept   = in_valid & in_ready;
    assign push0    = accept & (in_sel == DEST_REG);
    assign push1    = accept & (in_sel == DEST_MEM);

    assign out0_valid = ~empty0;
    assign out1_valid = ~empty1;
    assign pop0       = out0_valid & out0_ready;
    assign pop1       = out1_valid & out1_ready;

    sync_fifo_8bits #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo0 (
        .clk   (CLK),
        .rst   (RESET),
        .push  (push0),
        .pop   (pop0),
        .din   (in_data),
        .dout  (out0_data),
        .full  (full0),
        .empty (empty0)
    );

    sync_fifo_8bits #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo1 (
        .clk   (CLK),
        .rst   (RESET),
        .push  (push1),
        .pop   (pop1),
        .din   (in_data),
        .dout  (out1_data),
        .full  (full1),
        .empty (empty1)
    );

`ifdef DEMUX_1X2_COUNT_EN
    logic [CNT_WIDTH-1:0] cnt0_q;
    logic [CNT_WIDTH-1:0] cnt1_q;

    // Delivered-word counters, wrapping at 2^CNT_WIDTH
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (pop0) begin
                cnt0_q <= cnt0_q + CNT_WIDTH'(1);
            end
            if (pop1) begin
                cnt1_q <= cnt1_q + CNT_WIDTH'(1);
            end
        end
    end

    assign cnt0 = cnt0_q;
    assign cnt1 = cnt1_q;
`else
    assign cnt0 = '0;
    assign cnt1 = '0;
`endif

endmodule
